// File: rtl/imem_boot_loader.sv
// imem_boot_loader: streams host words into imem from addr 0, holds cpu in reset until loaded, flags halt on zero word (cycle counter only with IMEM_LOADER_CYCLE_CNT_EN)
module imem_boot_loader #(
    parameter int ADDR_W = 8,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_data,
    input  logic              in_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_reset,
    input  logic [31:0]       cpu_instruction,
    output logic [ADDR_W:0]   load_count,
    output logic              overflow,
    output logic              done
`ifdef IMEM_LOADER_CYCLE_CNT_EN
    ,
    output logic [CNT_W-1:0]  cycle_count
`endif
);
    localparam logic [1:0] LOAD = 2'd0, FLUSH = 2'd1, RUN = 2'd2, HALT = 2'd3;
    logic [1:0] state, state_n;
    logic [ADDR_W-1:0] wptr;
    logic accept, top, halt;
    always_comb begin
        in_ready = (state == LOAD) && !reset;
        accept = in_valid && in_ready;
        top = &wptr;
        halt = cpu_instruction == 32'h0;
        cpu_reset = (state == LOAD) || (state == FLUSH);
        state_n = (accept && (in_last || top)) ? FLUSH :
                  (state == FLUSH) ? RUN :
                  (state == RUN && halt) ? HALT : state;
    end
    // the pointer parks on the top address; the load ends on that word anyway
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= LOAD;
            wptr <= '0;
            imem_we <= 1'b0;
            imem_addr <= '0;
            imem_wdata <= '0;
            load_count <= '0;
            overflow <= 1'b0;
            done <= 1'b0;
        end else begin
            state <= state_n;
            imem_we <= accept;
            if (accept) begin
                imem_addr <= wptr;
                imem_wdata <= in_data;
                load_count <= load_count + (ADDR_W+1)'(1);
                wptr <= top ? wptr : wptr + ADDR_W'(1);
                overflow <= overflow | (top && !in_last);
            end
            if (state == RUN && halt) done <= 1'b1;
        end
    end
`ifdef IMEM_LOADER_CYCLE_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_count <= '0;
        else if (state == RUN && !halt && !(&cycle_count)) cycle_count <= cycle_count + CNT_W'(1);
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif
endmodule

// File: tb/tb_imem_boot_loader.sv
// tb_imem_boot_loader: directed vector table plus hand sequences for overflow, async reset and halt
module tb_imem_boot_loader;
    logic clk, reset, v, l, v2, l2;
    logic [31:0] d, d2, ci;
    logic rdy, we, crst, ovf, dn;
    logic [7:0] a;
    logic [31:0] wd;
    logic [8:0] lc;
    logic rdy2, we2, crst2, ovf2, dn2;
    logic [1:0] a2;
    logic [31:0] wd2;
    logic [2:0] lc2;
    logic [31:0] cc, cc2;
    int checks = 0, errors = 0;

    imem_boot_loader #(.ADDR_W(8), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .in_valid(v), .in_ready(rdy), .in_data(d), .in_last(l),
        .imem_we(we), .imem_addr(a), .imem_wdata(wd), .cpu_reset(crst), .cpu_instruction(ci),
        .load_count(lc), .overflow(ovf), .done(dn)
`ifdef IMEM_LOADER_CYCLE_CNT_EN
        , .cycle_count(cc)
`endif
    );

    imem_boot_loader #(.ADDR_W(2), .CNT_W(32)) dut2 (
        .clk(clk), .reset(reset), .in_valid(v2), .in_ready(rdy2), .in_data(d2), .in_last(l2),
        .imem_we(we2), .imem_addr(a2), .imem_wdata(wd2), .cpu_reset(crst2), .cpu_instruction(ci),
        .load_count(lc2), .overflow(ovf2), .done(dn2)
`ifdef IMEM_LOADER_CYCLE_CNT_EN
        , .cycle_count(cc2)
`endif
    );

`ifndef IMEM_LOADER_CYCLE_CNT_EN
    assign cc = '0;
    assign cc2 = '0;
`endif

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run still active at %0t, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic v; logic [31:0] d; logic l; logic [31:0] ci;
        logic we; logic [7:0] a; logic [31:0] wd; logic [8:0] lc;
        logic rdy; logic crst; logic dn; logic [31:0] cc;
    } vec_t;
    vec_t tv[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #3;
        v = 0; l = 0; d = 0; v2 = 0; l2 = 0; d2 = 0;
        reset = 1;
        #1;
        chk("rst_ready", rdy, 0);
        chk("rst_we", we, 0);
        chk("rst_addr", a, 0);
        chk("rst_wdata", wd, 0);
        chk("rst_cpu_reset", crst, 1);
        chk("rst_load_count", lc, 0);
        chk("rst_overflow", ovf, 0);
        chk("rst_done", dn, 0);
`ifdef IMEM_LOADER_CYCLE_CNT_EN
        chk("rst_cycle_count", cc, 0);
`endif
        @(posedge clk);
        #1;
        reset = 0;
        #1;
        chk("ready_after_reset", rdy, 1);
    endtask

    task automatic run_vec(input int i);
        v = tv[i].v; d = tv[i].d; l = tv[i].l; ci = tv[i].ci;
        @(posedge clk);
        #1;
        chk($sformatf("v%0d_we", i), we, tv[i].we);
        chk($sformatf("v%0d_addr", i), a, tv[i].a);
        chk($sformatf("v%0d_wdata", i), wd, tv[i].wd);
        chk($sformatf("v%0d_load_count", i), lc, tv[i].lc);
        chk($sformatf("v%0d_ready", i), rdy, tv[i].rdy);
        chk($sformatf("v%0d_cpu_reset", i), crst, tv[i].crst);
        chk($sformatf("v%0d_done", i), dn, tv[i].dn);
`ifdef IMEM_LOADER_CYCLE_CNT_EN
        chk($sformatf("v%0d_cycle_count", i), cc, tv[i].cc);
`endif
    endtask

    initial begin
        reset = 1; v = 0; l = 0; d = 0; v2 = 0; l2 = 0; d2 = 0; ci = 32'h13;
        // back-to-back load, release two edges after last accept, then 7 run cycles and halt
        tv[0]  = '{1, 32'h00F00093, 0, 32'h13, 1, 0, 32'h00F00093, 1, 1, 1, 0, 0};
        tv[1]  = '{1, 32'h01900113, 0, 32'h13, 1, 1, 32'h01900113, 2, 1, 1, 0, 0};
        tv[2]  = '{1, 32'h00000000, 1, 32'h13, 1, 2, 32'h00000000, 3, 0, 1, 0, 0};
        tv[3]  = '{1, 32'hDEADBEEF, 1, 32'h13, 0, 2, 32'h00000000, 3, 0, 0, 0, 0};
        tv[4]  = '{0, 32'h0, 0, 32'h13, 0, 2, 32'h0, 3, 0, 0, 0, 1};
        tv[5]  = '{0, 32'h0, 0, 32'h13, 0, 2, 32'h0, 3, 0, 0, 0, 2};
        tv[6]  = '{0, 32'h0, 0, 32'h13, 0, 2, 32'h0, 3, 0, 0, 0, 3};
        tv[7]  = '{0, 32'h0, 0, 32'h13, 0, 2, 32'h0, 3, 0, 0, 0, 4};
        tv[8]  = '{0, 32'h0, 0, 32'h13, 0, 2, 32'h0, 3, 0, 0, 0, 5};
        tv[9]  = '{0, 32'h0, 0, 32'h13, 0, 2, 32'h0, 3, 0, 0, 0, 6};
        tv[10] = '{1, 32'h5, 0, 32'h13, 0, 2, 32'h0, 3, 0, 0, 0, 7};
        tv[11] = '{0, 32'h0, 0, 32'h00, 0, 2, 32'h0, 3, 0, 0, 1, 7};
        // gapped valid, in_last without valid is ignored
        tv[12] = '{1, 32'h11111111, 0, 32'h13, 1, 0, 32'h11111111, 1, 1, 1, 0, 0};
        tv[13] = '{0, 32'hAAAAAAAA, 0, 32'h13, 0, 0, 32'h11111111, 1, 1, 1, 0, 0};
        tv[14] = '{1, 32'h22222222, 0, 32'h13, 1, 1, 32'h22222222, 2, 1, 1, 0, 0};
        tv[15] = '{0, 32'hBBBBBBBB, 1, 32'h13, 0, 1, 32'h22222222, 2, 1, 1, 0, 0};
        tv[16] = '{1, 32'h33333333, 0, 32'h13, 1, 2, 32'h33333333, 3, 1, 1, 0, 0};
        tv[17] = '{0, 32'hCCCCCCCC, 1, 32'h13, 0, 2, 32'h33333333, 3, 1, 1, 0, 0};
        tv[18] = '{1, 32'h44444444, 1, 32'h13, 1, 3, 32'h44444444, 4, 0, 1, 0, 0};
        tv[19] = '{0, 32'h0, 0, 32'h00, 0, 3, 32'h44444444, 4, 0, 0, 0, 0};

        do_reset();
        for (int i = 0; i < 12; i++) run_vec(i);
        ci = 32'h13;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("halt_done_hold", dn, 1);
            chk("halt_cpu_reset", crst, 0);
            chk("halt_ready", rdy, 0);
`ifdef IMEM_LOADER_CYCLE_CNT_EN
            chk("halt_cycle_frozen", cc, 7);
`endif
        end

        do_reset();
        for (int i = 12; i < 20; i++) run_vec(i);

        // async reset mid-clock after two accepts, reload restarts at address 0
        do_reset();
        v = 1; d = 32'hA0A0A0A0; l = 0;
        @(posedge clk);
        #1;
        d = 32'hB0B0B0B0;
        @(posedge clk);
        #1;
        chk("pre_async_load_count", lc, 2);
        chk("pre_async_addr", a, 1);
        #2;
        reset = 1;
        #1;
        chk("async_cpu_reset", crst, 1);
        chk("async_load_count", lc, 0);
        chk("async_we", we, 0);
        chk("async_addr", a, 0);
        chk("async_ready", rdy, 0);
        @(posedge clk);
        #1;
        chk("async_held_we", we, 0);
        reset = 0;
        d = 32'hC0C0C0C0; l = 1; ci = 32'h13;
        @(posedge clk);
        #1;
        chk("reload_we", we, 1);
        chk("reload_addr", a, 0);
        chk("reload_wdata", wd, 32'hC0C0C0C0);
        chk("reload_load_count", lc, 1);
        chk("reload_cpu_reset_flush", crst, 1);
        v = 0; l = 0;
        @(posedge clk);
        #1;
        chk("single_word_release", crst, 0);
        chk("single_word_done_low", dn, 0);
        ci = 32'h0;
        @(posedge clk);
        #1;
        chk("immediate_halt_done", dn, 1);
`ifdef IMEM_LOADER_CYCLE_CNT_EN
        chk("immediate_halt_count", cc, 0);
`endif
        ci = 32'h13;

        // overflow on the 2-bit address instance
        do_reset();
        v2 = 1; l2 = 0;
        for (int k = 0; k < 5; k++) begin
            d2 = 32'h100 + k;
            @(posedge clk);
            #1;
            if (k < 4) begin
                chk($sformatf("ovf_w%0d_we", k), we2, 1);
                chk($sformatf("ovf_w%0d_addr", k), a2, k);
                chk($sformatf("ovf_w%0d_wdata", k), wd2, 32'h100 + k);
                chk($sformatf("ovf_w%0d_load_count", k), lc2, k + 1);
                chk($sformatf("ovf_w%0d_overflow", k), ovf2, k == 3);
                chk($sformatf("ovf_w%0d_ready", k), rdy2, k != 3);
            end else begin
                chk("ovf_5th_we", we2, 0);
                chk("ovf_5th_load_count", lc2, 4);
                chk("ovf_5th_addr", a2, 3);
                chk("ovf_5th_ready", rdy2, 0);
                chk("ovf_release", crst2, 0);
                chk("ovf_sticky", ovf2, 1);
            end
        end
        v2 = 0;
        @(posedge clk);
        #1;
        chk("ovf_still_sticky", ovf2, 1);
        chk("ovf_no_write", we2, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
